// File: rtl/mic_array_sched_pkg.sv
// Shared constants and FSM encoding for the microphone array sequencer.
package mic_array_sched_pkg;

   // One I2S frame is 64 bit clocks; WS is high for the first half.
   localparam int FRAME_LEN = 64;
   localparam int WS_HALF   = 32;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

endpackage

// File: rtl/mic_array_sched_i2s_ws_gen.sv
// Word-select generator shared by all I2S decoders.
// ws is high for counts 0..31 and low for 32..63. When enable drops, the
// frame in progress finishes, then ws stays low with the counter parked at 0.
module i2s_ws_gen
   import mic_array_sched_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic ws
);

   logic [5:0] ws_cnt;
   logic       running;

   // Frame counter with graceful stop at the frame boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         ws_cnt  <= '0;
         ws      <= 1'b0;
         running <= 1'b0;
      end else if (!running) begin
         ws_cnt <= '0;
         if (enable) begin
            running <= 1'b1;
            ws      <= 1'b1;
         end else begin
            ws      <= 1'b0;
         end
      end else if (ws_cnt == 6'(FRAME_LEN - 1)) begin
         ws_cnt  <= '0;
         ws      <= enable;
         running <= enable;
      end else begin
         ws_cnt <= ws_cnt + 6'd1;
         ws     <= (ws_cnt + 6'd1) < 6'(WS_HALF);
      end
   end

endmodule

// File: rtl/mic_array_sched.sv
// Microphone array sequencer: drives WS, snapshots all channels when every
// decoder reports completion, then streams one channel per valid/ready beat.
// Optional build macro MIC_MASK_EN adds a chan_mask input; masked channels
// are skipped without bubbles and an all-zero mask counts the frame only.
module mic_array_sched
   import mic_array_sched_pkg::*;
#(
   parameter int NUM_MIC   = 8,
   parameter int DATAWIDTH = 24,
   parameter int CHW       = 3
) (
   input  logic                           clk_mic,
   input  logic                           rst_mic,
   input  logic                           enable,
   output logic                           ws,
   input  logic [NUM_MIC*DATAWIDTH-1:0]   mic_data,
   input  logic [NUM_MIC-1:0]             mic_recv_over,
`ifdef MIC_MASK_EN
   input  logic [NUM_MIC-1:0]             chan_mask,
`endif
   output logic                           s_valid,
   input  logic                           s_ready,
   output logic [DATAWIDTH-1:0]           s_data,
   output logic [CHW-1:0]                 s_chan,
   output logic                           s_last,
   output logic [15:0]                    frame_cnt,
   output logic                           overflow,
   output logic                           sync_err,
   input  logic                           clr_err
);

   // Lowest set bit at or above 'from'; MSB of the result is the found flag.
   function automatic logic [CHW:0] first_from(input logic [NUM_MIC-1:0] m, input int from);
      logic [CHW:0] r;
      r = '0;
      for (int i = NUM_MIC - 1; i >= 0; i--) begin
         if (m[i] && (i >= from)) r = {1'b1, CHW'(i)};
      end
      return r;
   endfunction

   // Highest set bit; identifies the channel that carries s_last.
   function automatic logic [CHW-1:0] last_set(input logic [NUM_MIC-1:0] m);
      logic [CHW-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_MIC; i++) begin
         if (m[i]) r = CHW'(i);
      end
      return r;
   endfunction

   state_t               state;
   logic [DATAWIDTH-1:0] snap    [NUM_MIC];
   logic [DATAWIDTH-1:0] mic_arr [NUM_MIC];
   logic [NUM_MIC-1:0]   act_mask;
   logic [NUM_MIC-1:0]   mask_q;
   logic [CHW-1:0]       last_q;
   logic [CHW:0]         new_first;
   logic [CHW:0]         next_beat;
   logic [CHW-1:0]       new_last;
   logic                 trigger;
   logic                 partial;
   logic                 handshake;
   logic                 drop;
   logic                 load;

`ifdef MIC_MASK_EN
   assign act_mask = chan_mask;
`else
   assign act_mask = '1;
`endif

   i2s_ws_gen u_ws_gen (
      .clk    (clk_mic),
      .rst    (rst_mic),
      .enable (enable),
      .ws     (ws)
   );

   // Unpack the flat decoder bus into per-channel words.
   always_comb begin
      for (int k = 0; k < NUM_MIC; k++) begin
         mic_arr[k] = mic_data[k*DATAWIDTH +: DATAWIDTH];
      end
   end

   assign trigger   = &mic_recv_over;
   assign partial   = (|mic_recv_over) && !trigger;
   assign handshake = s_valid && s_ready;
   // A trigger during DRAIN is only accepted when it lands on the final handshake.
   assign drop      = trigger && (state == ST_DRAIN) && !(handshake && s_last);
   assign load      = trigger && !drop;
   assign new_first = first_from(act_mask, 0);
   assign new_last  = last_set(act_mask);
   assign next_beat = first_from(mask_q, int'(s_chan) + 1);

   // Drain FSM, snapshot buffer, sticky flags and frame counter.
   always_ff @(posedge clk_mic) begin
      if (rst_mic) begin
         state     <= ST_IDLE;
         s_valid   <= 1'b0;
         s_data    <= '0;
         s_chan    <= '0;
         s_last    <= 1'b0;
         frame_cnt <= '0;
         overflow  <= 1'b0;
         sync_err  <= 1'b0;
         mask_q    <= '0;
         last_q    <= '0;
         for (int k = 0; k < NUM_MIC; k++) snap[k] <= '0;
      end else begin
         if (partial)      sync_err <= 1'b1;
         else if (clr_err) sync_err <= 1'b0;

         if (drop)         overflow <= 1'b1;
         else if (clr_err) overflow <= 1'b0;

         if (load) begin
            for (int k = 0; k < NUM_MIC; k++) snap[k] <= mic_arr[k];
            mask_q    <= act_mask;
            last_q    <= new_last;
            frame_cnt <= frame_cnt + 16'd1;
            if (new_first[CHW]) begin
               state   <= ST_DRAIN;
               s_valid <= 1'b1;
               s_chan  <= new_first[CHW-1:0];
               s_data  <= mic_arr[new_first[CHW-1:0]];
               s_last  <= (new_first[CHW-1:0] == new_last);
            end else begin
               state   <= ST_IDLE;
               s_valid <= 1'b0;
               s_last  <= 1'b0;
            end
         end else if ((state == ST_DRAIN) && handshake) begin
            if (s_last) begin
               state   <= ST_IDLE;
               s_valid <= 1'b0;
               s_last  <= 1'b0;
            end else begin
               s_chan  <= next_beat[CHW-1:0];
               s_data  <= snap[next_beat[CHW-1:0]];
               s_last  <= (next_beat[CHW-1:0] == last_q);
            end
         end
      end
   end

endmodule
